sram_arbiter: RTL and testbench

//   Shares the single external async SRAM port between two requesters: the video

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/sram_arb_pick.sv | 24 ++
 rtl/sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM arbiter (video scanout vs CPU/host).
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W      = 13;
  localparam int unsigned SRAM_DATA_W      = 16;
  localparam int unsigned SRAM_STARVE_LIM  = 4;
  localparam int unsigned SRAM_TURNAROUND  = 1;

  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational priority picker; grant is one-hot {cpu, vid}.
module sram_arb_pick (
  input  logic       en,
  input  logic       vid_req,
  input  logic       vid_urgent,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       starved,
  input  logic       rd_block,
  output logic [1:0] grant
);

  logic pick_vid;
  logic pick_cpu;

  // The winner is chosen first; a winner held off by turnaround gets nothing.
  always_comb begin
    pick_vid = vid_req && (vid_urgent || !(cpu_req && starved));
    pick_cpu = cpu_req && !pick_vid;
    grant    = {en && pick_cpu && !(rd_block && !cpu_we),
                en && pick_vid && !rd_block};
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port async SRAM arbiter: video priority, CPU starvation guard, W->R turnaround.
// Optional byte lanes under SRAM_ARBITER_BYTELANE_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = SRAM_ADDR_W,
  parameter int unsigned DATA_W       = SRAM_DATA_W,
  parameter int unsigned STARVE_LIMIT = SRAM_STARVE_LIM,
  parameter int unsigned TURNAROUND   = SRAM_TURNAROUND
) (
  input  logic              clk_core,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic              vid_urgent,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_wr,
  output logic [DATA_W-1:0] host_to_sram,
`ifdef SRAM_ARBITER_BYTELANE_EN
  input  logic [1:0]        cpu_be,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
`endif
  input  logic [DATA_W-1:0] sram_to_host
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  owner_e              own1_q, own1_d, own2_q, own2_d;
  logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
  logic                sram_wr_q, sram_wr_d;
  logic [DATA_W-1:0]   host_to_sram_q, host_to_sram_d;
  logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [1:0]          grant;
  logic                starved;
  logic                rd_block;

  assign starved  = (wait_q == CNT_W'(STARVE_LIMIT));
  assign rd_block = (TURNAROUND != 0) && (state_q == WR);

  sram_arb_pick u_pick (
    .en         (reset_n),
    .vid_req    (vid_req),
    .vid_urgent (vid_urgent),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .starved    (starved),
    .rd_block   (rd_block),
    .grant      (grant)
  );

  assign vid_gnt = grant[0];
  assign cpu_gnt = grant[1];

  // Next state, SRAM drive, starvation counter and read-return pipeline.
  always_comb begin
    state_d        = IDLE;
    wait_d         = wait_q;
    own1_d         = OWN_NONE;
    own2_d         = own1_q;
    sram_a_d       = sram_a_q;
    sram_wr_d      = 1'b0;
    host_to_sram_d = host_to_sram_q;
    vid_rdata_d    = vid_rdata_q;
    cpu_rdata_d    = cpu_rdata_q;

    if (grant[0]) begin
      state_d  = RD;
      own1_d   = OWN_VID;
      sram_a_d = vid_addr;
    end else if (grant[1]) begin
      sram_a_d = cpu_addr;
      if (cpu_we) begin
        state_d        = WR;
        sram_wr_d      = 1'b1;
        host_to_sram_d = cpu_wdata;
      end else begin
        state_d = RD;
        own1_d  = OWN_CPU;
      end
    end else if (rd_block && (vid_req || cpu_req)) begin
      state_d = TURN;
    end

    if (!cpu_req || grant[1]) begin
      wait_d = '0;
    end else if (!starved) begin
      wait_d = wait_q + CNT_W'(1);
    end

    if (own1_q == OWN_VID) vid_rdata_d = sram_to_host;
    if (own1_q == OWN_CPU) cpu_rdata_d = sram_to_host;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wait_q         <= '0;
      own1_q         <= OWN_NONE;
      own2_q         <= OWN_NONE;
      sram_a_q       <= '0;
      sram_wr_q      <= 1'b0;
      host_to_sram_q <= '0;
      vid_rdata_q    <= '0;
      cpu_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      own1_q         <= own1_d;
      own2_q         <= own2_d;
      sram_a_q       <= sram_a_d;
      sram_wr_q      <= sram_wr_d;
      host_to_sram_q <= host_to_sram_d;
      vid_rdata_q    <= vid_rdata_d;
      cpu_rdata_q    <= cpu_rdata_d;
    end
  end

  assign sram_a       = sram_a_q;
  assign sram_wr      = sram_wr_q;
  assign host_to_sram = host_to_sram_q;
  assign vid_rdata    = vid_rdata_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign vid_rvalid   = (own2_q == OWN_VID);
  assign cpu_rvalid   = (own2_q == OWN_CPU);

`ifdef SRAM_ARBITER_BYTELANE_EN
  logic [1:0] be_n_q, be_n_d;

  // Lane enables follow sram_a; only CPU writes can mask lanes.
  always_comb begin
    be_n_d = be_n_q;
    if (grant[0])      be_n_d = 2'b00;
    else if (grant[1]) be_n_d = cpu_we ? ~cpu_be : 2'b00;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) be_n_q <= 2'b11;
    else          be_n_q <= be_n_d;
  end

  assign sram_lb_n = be_n_q[0];
  assign sram_ub_n = be_n_q[1];
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter (default build, TURNAROUND=1 and TURNAROUND=0 instances).
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        vid_req, vid_urgent, cpu_req, cpu_we;
  logic [12:0] vid_addr, cpu_addr;
  logic [15:0] cpu_wdata;

  logic        vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, sram_wr;
  logic [15:0] vid_rdata, cpu_rdata, host_to_sram, sram_to_host;
  logic [12:0] sram_a;

  logic        b_vid_gnt, b_vid_rvalid, b_cpu_gnt, b_cpu_rvalid, b_sram_wr;
  logic [15:0] b_vid_rdata, b_cpu_rdata, b_host_to_sram;
  logic [15:0] b_sram_to_host = 16'h0000;
  logic [12:0] b_sram_a;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] vid_q[$];
  logic [15:0] cpu_q[$];
  logic [15:0] exp_wr[int];
  logic [15:0] mem [8192];
  bit          written [8192];

  always #5 clk_core = ~clk_core;

  sram_arbiter #(.TURNAROUND(1)) dut_a (
    .clk_core(clk_core), .reset_n(reset_n),
    .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .sram_a(sram_a), .sram_wr(sram_wr), .host_to_sram(host_to_sram),
    .sram_to_host(sram_to_host)
  );

  sram_arbiter #(.TURNAROUND(0)) dut_b (
    .clk_core(clk_core), .reset_n(reset_n),
    .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr),
    .vid_gnt(b_vid_gnt), .vid_rdata(b_vid_rdata), .vid_rvalid(b_vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
    .sram_a(b_sram_a), .sram_wr(b_sram_wr), .host_to_sram(b_host_to_sram),
    .sram_to_host(b_sram_to_host)
  );

  function automatic logic [15:0] init_val(input logic [12:0] a);
    return (a == 13'h0123) ? 16'hBEEF : ({3'b000, a} ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [12:0] a);
    return exp_wr.exists(int'(a)) ? exp_wr[int'(a)] : init_val(a);
  endfunction

  // Async SRAM model: write at the end of a write cycle, combinational read.
  always @(posedge clk_core) begin
    if (sram_wr) begin
      mem[sram_a]     <= host_to_sram;
      written[sram_a] <= 1'b1;
    end
  end
  always_comb sram_to_host = written[sram_a] ? mem[sram_a] : init_val(sram_a);

  // Scoreboard: push on accepted reads, pop on rvalid.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk_core);
      if (reset_n) begin
        if (vid_req && vid_gnt) vid_q.push_back(ref_rd(vid_addr));
        if (cpu_req && cpu_gnt) begin
          if (cpu_we) exp_wr[int'(cpu_addr)] = cpu_wdata;
          else        cpu_q.push_back(ref_rd(cpu_addr));
        end
      end
      if (vid_rvalid) begin
        n_chk++;
        if (vid_q.size() == 0) $display("FAIL vid_rvalid_unexpected: rvalid=1 with nothing outstanding, required 0");
        else begin
          e = vid_q.pop_front();
          if (vid_rdata !== e) $display("FAIL vid_rdata: got %h required %h", vid_rdata, e);
          else n_pass++;
        end
      end
      if (cpu_rvalid) begin
        n_chk++;
        if (cpu_q.size() == 0) $display("FAIL cpu_rvalid_unexpected: rvalid=1 with nothing outstanding, required 0");
        else begin
          e = cpu_q.pop_front();
          if (cpu_rdata !== e) $display("FAIL cpu_rdata: got %h required %h", cpu_rdata, e);
          else n_pass++;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk_core); #1;
  endtask

  task automatic drain;
    vid_req = 1'b0; cpu_req = 1'b0; vid_urgent = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset;
    reset_n = 1'b0; vid_req = 1'b1; vid_urgent = 1'b0; vid_addr = 13'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123; cpu_wdata = 16'h0000;
    repeat (2) @(negedge clk_core);
    n_chk++;
    if ({vid_gnt, cpu_gnt, sram_wr, vid_rvalid, cpu_rvalid} !== 5'b0 || sram_a !== 13'h0)
      $display("FAIL reset_outputs: gnt/wr/rvalid=%b sram_a=%h required 00000 and 0000",
               {vid_gnt, cpu_gnt, sram_wr, vid_rvalid, cpu_rvalid}, sram_a);
    else n_pass++;
    step(); reset_n = 1'b1;
    @(negedge clk_core);
    n_chk++;
    if (vid_gnt !== 1'b1 || cpu_gnt !== 1'b0)
      $display("FAIL reset_first_grant: vid_gnt=%b cpu_gnt=%b required 1 0", vid_gnt, cpu_gnt);
    else n_pass++;
    step();
    drain();
  endtask

  task automatic test_cpu_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    @(negedge clk_core);
    n_chk++;
    if (cpu_gnt !== 1'b1) $display("FAIL cpu_read_gnt: got %b required 1", cpu_gnt); else n_pass++;
    step(); cpu_req = 1'b0;
    @(negedge clk_core);
    n_chk++;
    if (sram_a !== 13'h0123 || sram_wr !== 1'b0 || cpu_rvalid !== 1'b0)
      $display("FAIL cpu_read_t1: sram_a=%h wr=%b rvalid=%b required 0123 0 0", sram_a, sram_wr, cpu_rvalid);
    else n_pass++;
    @(negedge clk_core);
    n_chk++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF)
      $display("FAIL cpu_read_t2: rvalid=%b rdata=%h required 1 beef", cpu_rvalid, cpu_rdata);
    else n_pass++;
    @(negedge clk_core);
    n_chk++;
    if (cpu_rvalid !== 1'b0) $display("FAIL cpu_read_pulse: rvalid=%b required 0", cpu_rvalid); else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back;
    logic [12:0] prev;
    cpu_req = 1'b1; cpu_we = 1'b0;
    prev = 13'h0;
    for (int i = 0; i < 6; i++) begin
      cpu_addr = 13'h0100 + 13'(i);
      @(negedge clk_core);
      n_chk++;
      if (cpu_gnt !== 1'b1) $display("FAIL b2b_gnt[%0d]: got %b required 1", i, cpu_gnt); else n_pass++;
      if (i > 0) begin
        n_chk++;
        if (sram_a !== prev) $display("FAIL b2b_sram_a[%0d]: got %h required %h", i, sram_a, prev);
        else n_pass++;
      end
      prev = cpu_addr;
      step();
    end
    drain();
  endtask

  task automatic test_starvation;
    logic exp_c;
    vid_req = 1'b1; vid_urgent = 1'b0; vid_addr = 13'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_core);
      exp_c = ((i % 5) == 4);
      n_chk++;
      if (cpu_gnt !== exp_c || vid_gnt !== !exp_c)
        $display("FAIL starve_cycle[%0d]: cpu_gnt=%b vid_gnt=%b required %b %b", i, cpu_gnt, vid_gnt, exp_c, !exp_c);
      else n_pass++;
      step();
    end
    drain();
  endtask

  task automatic test_urgent;
    int cpu_wins;
    cpu_wins = 0;
    vid_req = 1'b1; vid_urgent = 1'b1; vid_addr = 13'h0300;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_core);
      if (cpu_gnt === 1'b1) cpu_wins++;
      if (i < 11) step();
    end
    n_chk++;
    if (cpu_wins != 0) $display("FAIL urgent_cpu_gnt: cpu granted %0d times, required 0", cpu_wins); else n_pass++;
    n_chk++;
    if (dut_a.wait_q !== 3'd4) $display("FAIL urgent_counter_sat: got %0d required 4", dut_a.wait_q); else n_pass++;
    step(); vid_urgent = 1'b0;
    @(negedge clk_core);
    n_chk++;
    if (cpu_gnt !== 1'b1 || vid_gnt !== 1'b0)
      $display("FAIL urgent_release: cpu_gnt=%b vid_gnt=%b required 1 0", cpu_gnt, vid_gnt);
    else n_pass++;
    step();
    drain();
  endtask

  task automatic test_turnaround;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 16'hA5A5;
    @(negedge clk_core);
    n_chk++;
    if (cpu_gnt !== 1'b1 || b_cpu_gnt !== 1'b1)
      $display("FAIL turn_write_gnt: a=%b b=%b required 1 1", cpu_gnt, b_cpu_gnt);
    else n_pass++;
    step(); cpu_req = 1'b0; cpu_we = 1'b0; vid_req = 1'b1; vid_addr = 13'h0010;
    @(negedge clk_core);
    n_chk++;
    if (sram_wr !== 1'b1 || sram_a !== 13'h0010 || host_to_sram !== 16'hA5A5)
      $display("FAIL turn_write_drive: wr=%b a=%h d=%h required 1 0010 a5a5", sram_wr, sram_a, host_to_sram);
    else n_pass++;
    n_chk++;
    if (vid_gnt !== 1'b0) $display("FAIL turn_block: vid_gnt=%b required 0", vid_gnt); else n_pass++;
    n_chk++;
    if (b_vid_gnt !== 1'b1 || b_sram_wr !== 1'b1)
      $display("FAIL turn0_no_gap: vid_gnt=%b wr=%b required 1 1", b_vid_gnt, b_sram_wr);
    else n_pass++;
    step();
    @(negedge clk_core);
    n_chk++;
    if (sram_wr !== 1'b0 || vid_gnt !== 1'b1)
      $display("FAIL turn_idle: wr=%b vid_gnt=%b required 0 1", sram_wr, vid_gnt);
    else n_pass++;
    n_chk++;
    if (b_sram_wr !== 1'b0 || b_sram_a !== 13'h0010)
      $display("FAIL turn0_read_drive: wr=%b a=%h required 0 0010", b_sram_wr, b_sram_a);
    else n_pass++;
    step();
    drain();
  endtask

  task automatic test_reset_mid_access;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0040; cpu_wdata = 16'h1234;
    @(negedge clk_core);
    step(); cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk_core);
    n_chk++;
    if (sram_wr !== 1'b1) $display("FAIL rst_wr_before: wr=%b required 1", sram_wr); else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_chk++;
    if (sram_wr !== 1'b0 || sram_a !== 13'h0)
      $display("FAIL rst_wr_drop: wr=%b a=%h required 0 0000", sram_wr, sram_a);
    else n_pass++;
    step(); reset_n = 1'b1;
    cpu_req = 1'b1; cpu_addr = 13'h0055;
    @(negedge clk_core);
    n_chk++;
    if (cpu_gnt !== 1'b1) $display("FAIL rst_rd_gnt: got %b required 1", cpu_gnt); else n_pass++;
    step(); cpu_req = 1'b0;
    #1 reset_n = 1'b0;
    vid_q.delete(); cpu_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_core);
      n_chk++;
      if (cpu_rvalid !== 1'b0 || vid_rvalid !== 1'b0)
        $display("FAIL rst_no_rvalid[%0d]: cpu=%b vid=%b required 0 0", i, cpu_rvalid, vid_rvalid);
      else n_pass++;
      if (i == 1) begin
        @(posedge clk_core); #1 reset_n = 1'b1;
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_back_to_back();
    test_starvation();
    test_urgent();
    test_turnaround();
    test_reset_mid_access();
    n_chk++;
    if (vid_q.size() != 0 || cpu_q.size() != 0)
      $display("FAIL outstanding_reads: vid=%0d cpu=%0d required 0 0", vid_q.size(), cpu_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
